// File: rtl/m_multi_linked_list.sv
// Multiple FIFO queues sharing one storage pool through per-entry next-pointers.
// Unused entries are kept on a free list. Each queue can be flushed onto the free list in one cycle.
//
// state  | meaning
// S_INIT | write next[i]=i+1 for each entry, one per cycle; all handshakes blocked
// S_RUN  | normal push/pop/flush operation
module m_multi_linked_list #(
   parameter int WIDTH     = 4,
   parameter int DEPTH     = 16,
   parameter int NUM_LISTS = 4,
   localparam int L2_DEPTH = $clog2(DEPTH),
   localparam int L2_LISTS = $clog2(NUM_LISTS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push_vld,
   output logic                  push_rdy,
   input  logic [L2_LISTS-1:0]   push_id,
   input  logic [WIDTH-1:0]      push,
   input  logic [L2_LISTS-1:0]   pop_id,
   output logic                  pop_vld,
   input  logic                  pop_rdy,
   output logic [WIDTH-1:0]      pop,
   input  logic                  flush_vld,
   output logic                  flush_rdy,
   input  logic [L2_LISTS-1:0]   flush_id,
   output logic [NUM_LISTS-1:0]  empty,
   output logic [L2_DEPTH:0]     free_cnt,
   output logic                  init_done
);

   typedef enum logic {S_INIT, S_RUN} state_t;

   localparam logic [L2_DEPTH:0]   CNT_ONE  = (L2_DEPTH+1)'(1);
   localparam logic [L2_DEPTH:0]   CNT_FULL = (L2_DEPTH+1)'(DEPTH);
   localparam logic [L2_DEPTH-1:0] IDX_LAST = L2_DEPTH'(DEPTH-1);

   state_t state_q, state_d;
   logic [L2_DEPTH-1:0] init_cnt_q;
   logic                run, init_last;

   logic [WIDTH-1:0]    data [DEPTH];
   logic [L2_DEPTH-1:0] nxt  [DEPTH];

   logic [L2_DEPTH-1:0] head_q [NUM_LISTS];
   logic [L2_DEPTH-1:0] head_d [NUM_LISTS];
   logic [L2_DEPTH-1:0] tail_q [NUM_LISTS];
   logic [L2_DEPTH-1:0] tail_d [NUM_LISTS];
   logic [L2_DEPTH:0]   cnt_q  [NUM_LISTS];
   logic [L2_DEPTH:0]   cnt_d  [NUM_LISTS];

   logic [L2_DEPTH-1:0] free_head_q, free_head_d;
   logic [L2_DEPTH-1:0] free_tail_q, free_tail_d;
   logic [L2_DEPTH:0]   free_cnt_q, free_cnt_d;

   logic                lnk_we, fre_we;
   logic [L2_DEPTH-1:0] lnk_addr, lnk_val, fre_addr, fre_val;

   logic                push_fire, pop_fire, flush_fire, same_list;
   logic [L2_DEPTH-1:0] e, h;

   // FSM: INIT is timed by a down-counter that ends on terminal count zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_INIT;
         init_cnt_q <= IDX_LAST;
      end else begin
         state_q <= state_d;
         if (state_q == S_INIT) init_cnt_q <= init_cnt_q - 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_INIT:  if (init_cnt_q == '0) state_d = S_RUN;
         S_RUN:   state_d = S_RUN;
         default: state_d = S_INIT;
      endcase
   end

   assign run       = (state_q == S_RUN);
   assign init_last = (state_q == S_INIT) && (init_cnt_q == '0);
   assign init_done = run;
   assign free_cnt  = free_cnt_q;

   assign flush_rdy = run;
   assign push_rdy  = run && !flush_vld && (free_cnt_q != '0);
   assign pop_vld   = run && !flush_vld && (cnt_q[pop_id] != '0);
   assign pop       = data[head_q[pop_id]];

   assign push_fire  = push_vld && push_rdy;
   assign pop_fire   = pop_vld && pop_rdy;
   assign flush_fire = flush_vld && flush_rdy;
   assign same_list  = push_fire && pop_fire && (push_id == pop_id);
   assign e          = free_head_q;
   assign h          = head_q[pop_id];

   always_comb begin
      for (int i = 0; i < NUM_LISTS; i++) begin
         empty[i] = (cnt_q[i] == '0);
      end
   end

   always_comb begin
      head_d      = head_q;
      tail_d      = tail_q;
      cnt_d       = cnt_q;
      free_head_d = free_head_q;
      free_tail_d = free_tail_q;
      free_cnt_d  = free_cnt_q;
      lnk_we      = 1'b0;
      lnk_addr    = '0;
      lnk_val     = '0;
      fre_we      = 1'b0;
      fre_addr    = '0;
      fre_val     = '0;
      if (init_last) begin
         free_head_d = '0;
         free_tail_d = IDX_LAST;
         free_cnt_d  = CNT_FULL;
      end else if (flush_fire) begin
         if (cnt_q[flush_id] != '0) begin
            if (free_cnt_q == '0) begin
               free_head_d = head_q[flush_id];
            end else begin
               fre_we   = 1'b1;
               fre_addr = free_tail_q;
               fre_val  = head_q[flush_id];
            end
            free_tail_d     = tail_q[flush_id];
            free_cnt_d      = free_cnt_q + cnt_q[flush_id];
            cnt_d[flush_id] = '0;
         end
      end else begin
         if (pop_fire) begin
            head_d[pop_id] = nxt[h];
            cnt_d[pop_id]  = cnt_q[pop_id] - CNT_ONE;
         end
         if (push_fire) begin
            // a same-list pop of the only entry leaves the pushed entry as the whole list
            if ((cnt_q[push_id] == '0) || (same_list && (cnt_q[push_id] == CNT_ONE))) begin
               head_d[push_id] = e;
            end else begin
               lnk_we   = 1'b1;
               lnk_addr = tail_q[push_id];
               lnk_val  = e;
            end
            tail_d[push_id] = e;
            cnt_d[push_id]  = cnt_d[push_id] + CNT_ONE;
         end
         if (push_fire && pop_fire) begin
            if (free_cnt_q == CNT_ONE) begin
               free_head_d = h;
            end else begin
               free_head_d = nxt[e];
               fre_we      = 1'b1;
               fre_addr    = free_tail_q;
               fre_val     = h;
            end
            free_tail_d = h;
         end else if (push_fire) begin
            free_head_d = nxt[e];
            free_cnt_d  = free_cnt_q - CNT_ONE;
         end else if (pop_fire) begin
            if (free_cnt_q == '0) begin
               free_head_d = h;
            end else begin
               fre_we   = 1'b1;
               fre_addr = free_tail_q;
               fre_val  = h;
            end
            free_tail_d = h;
            free_cnt_d  = free_cnt_q + CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_LISTS; i++) begin
            head_q[i] <= '0;
            tail_q[i] <= '0;
            cnt_q[i]  <= '0;
         end
         free_head_q <= '0;
         free_tail_q <= '0;
         free_cnt_q  <= '0;
      end else begin
         head_q      <= head_d;
         tail_q      <= tail_d;
         cnt_q       <= cnt_d;
         free_head_q <= free_head_d;
         free_tail_q <= free_tail_d;
         free_cnt_q  <= free_cnt_d;
      end
   end

   // Storage and links are not reset; INIT rebuilds the links
   always_ff @(posedge clk) begin
      if (push_fire) data[e] <= push;
   end

   always_ff @(posedge clk) begin
      if (state_q == S_INIT) nxt[init_cnt_q] <= init_cnt_q + 1'b1;
      if (lnk_we) nxt[lnk_addr] <= lnk_val;
      if (fre_we) nxt[fre_addr] <= fre_val;
   end

endmodule

// File: tb/tb_m_multi_linked_list.sv
// Randomised and directed bench for m_multi_linked_list against a per-list queue model.
module tb_m_multi_linked_list;
   localparam int DEPTH = 16;
   localparam int NL    = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       push_vld, push_rdy, pop_vld, pop_rdy, flush_vld, flush_rdy, init_done;
   logic [1:0] push_id, pop_id, flush_id;
   logic [3:0] push, pop, empty;
   logic [4:0] free_cnt;

   int errors = 0;
   int checks = 0;
   logic [3:0] mq [NL][$];

   m_multi_linked_list dut (
      .clk(clk), .rst(rst),
      .push_vld(push_vld), .push_rdy(push_rdy), .push_id(push_id), .push(push),
      .pop_id(pop_id), .pop_vld(pop_vld), .pop_rdy(pop_rdy), .pop(pop),
      .flush_vld(flush_vld), .flush_rdy(flush_rdy), .flush_id(flush_id),
      .empty(empty), .free_cnt(free_cnt), .init_done(init_done)
   );

   always #5 clk = ~clk;

   function automatic int m_free();
      int s = DEPTH;
      for (int i = 0; i < NL; i++) s -= mq[i].size();
      return s;
   endfunction

   function automatic logic [3:0] m_empty();
      logic [3:0] r;
      for (int i = 0; i < NL; i++) r[i] = (mq[i].size() == 0);
      return r;
   endfunction

   task automatic set_in(input logic pv, input logic [1:0] pid, input logic [3:0] pd,
                         input logic pr, input logic [1:0] qid, input logic fv, input logic [1:0] fid);
      @(negedge clk);
      push_vld = pv; push_id = pid; push = pd;
      pop_rdy = pr; pop_id = qid;
      flush_vld = fv; flush_id = fid;
      #1;
   endtask

   // Applies the handshake rules to the model at the clock edge
   task automatic tick();
      bit fl, psh, pp;
      logic [3:0] v;
      fl  = flush_vld;
      psh = push_vld && !fl && (m_free() != 0);
      pp  = pop_rdy && !fl && (mq[pop_id].size() != 0);
      @(posedge clk);
      if (fl) mq[flush_id].delete();
      else begin
         if (pp) v = mq[pop_id].pop_front();
         if (psh) mq[push_id].push_back(push);
      end
   endtask

   task automatic wait_init(input string nm);
      int n = 0;
      while (!init_done && n < 40) begin
         @(posedge clk); #1; n++;
      end
      checks++;
      if (n !== 16) begin errors++; $display("FAIL %s_cycles: got %0d exp 16", nm, n); end
      checks++;
      if (free_cnt !== 5'd16) begin errors++; $display("FAIL %s_free: got %0d exp 16", nm, free_cnt); end
      checks++;
      if (empty !== 4'hF) begin errors++; $display("FAIL %s_empty: got %b exp 1111", nm, empty); end
      checks++;
      if (push_rdy !== 1'b1) begin errors++; $display("FAIL %s_push_rdy: got %b exp 1", nm, push_rdy); end
   endtask

   task automatic drain(input string nm);
      for (int l = 0; l < NL; l++) begin
         while (mq[l].size() != 0) begin
            set_in(0, 0, 0, 1, l[1:0], 0, 0);
            checks++;
            if (pop_vld !== 1'b1 || pop !== mq[l][0]) begin
               errors++;
               $display("FAIL %s_pop l%0d: got vld=%b d=%h exp vld=1 d=%h", nm, l, pop_vld, pop, mq[l][0]);
            end
            tick();
         end
      end
      set_in(0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (free_cnt !== 5'd16 || empty !== 4'hF) begin
         errors++; $display("FAIL %s_drained: got free=%0d empty=%b exp 16 1111", nm, free_cnt, empty);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      push_vld = 0; push_id = 0; push = 0; pop_rdy = 0; pop_id = 0; flush_vld = 0; flush_id = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({push_rdy, pop_vld, flush_rdy, init_done} !== 4'b0000 || free_cnt !== 5'd0 || empty !== 4'hF) begin
         errors++;
         $display("FAIL reset_vals: got rdy/vld/frdy/done=%b free=%0d empty=%b exp 0000 0 1111",
                  {push_rdy, pop_vld, flush_rdy, init_done}, free_cnt, empty);
      end
      rst = 1'b0;
      wait_init("init");
   endtask

   task automatic test_fifo_order();
      logic [3:0] vals [4] = '{4'hA, 4'hB, 4'hC, 4'hD};
      for (int i = 0; i < 4; i++) begin
         set_in(1, (i == 3) ? 2'd0 : 2'd2, vals[i], 0, 0, 0, 0);
         checks++;
         if (push_rdy !== 1'b1) begin errors++; $display("FAIL order_push_rdy %0d: got %b exp 1", i, push_rdy); end
         tick();
      end
      set_in(0, 0, 0, 0, 2, 0, 0);
      checks++;
      if (free_cnt !== 5'd12 || empty !== 4'b1010) begin
         errors++; $display("FAIL order_status: got free=%0d empty=%b exp 12 1010", free_cnt, empty);
      end
      for (int i = 0; i < 4; i++) begin
         set_in(0, 0, 0, 1, (i == 3) ? 2'd0 : 2'd2, 0, 0);
         checks++;
         if (pop_vld !== 1'b1 || pop !== vals[i]) begin
            errors++; $display("FAIL order_pop %0d: got vld=%b d=%h exp 1 %h", i, pop_vld, pop, vals[i]);
         end
         tick();
      end
      drain("order");
   endtask

   task automatic test_full();
      for (int i = 0; i < 16; i++) begin
         set_in(1, i[1:0], 4'($urandom_range(0, 15)), 0, 0, 0, 0);
         checks++;
         if (push_rdy !== 1'b1) begin errors++; $display("FAIL full_push_rdy %0d: got %b exp 1", i, push_rdy); end
         tick();
      end
      set_in(1, 1, 4'h7, 1, 0, 0, 0);
      checks++;
      if (push_rdy !== 1'b0 || free_cnt !== 5'd0) begin
         errors++; $display("FAIL full_block: got rdy=%b free=%0d exp 0 0", push_rdy, free_cnt);
      end
      checks++;
      if (pop_vld !== 1'b1 || pop !== mq[0][0]) begin
         errors++; $display("FAIL full_pop: got vld=%b d=%h exp 1 %h", pop_vld, pop, mq[0][0]);
      end
      tick();
      set_in(0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (push_rdy !== 1'b1 || free_cnt !== 5'd1) begin
         errors++; $display("FAIL full_after_pop: got rdy=%b free=%0d exp 1 1", push_rdy, free_cnt);
      end
      drain("full");
   endtask

   task automatic test_push_pop_same();
      set_in(1, 1, 4'h5, 0, 0, 0, 0);
      tick();
      set_in(1, 1, 4'h9, 1, 1, 0, 0);
      checks++;
      if (pop_vld !== 1'b1 || pop !== 4'h5 || free_cnt !== 5'd15) begin
         errors++; $display("FAIL same_pop: got vld=%b d=%h free=%0d exp 1 5 15", pop_vld, pop, free_cnt);
      end
      tick();
      set_in(0, 0, 0, 0, 1, 0, 0);
      checks++;
      if (pop_vld !== 1'b1 || pop !== 4'h9 || free_cnt !== 5'd15) begin
         errors++; $display("FAIL same_after: got vld=%b d=%h free=%0d exp 1 9 15", pop_vld, pop, free_cnt);
      end
      set_in(0, 0, 0, 1, 1, 0, 0);
      tick();
      set_in(0, 0, 0, 0, 1, 0, 0);
      checks++;
      if (empty[1] !== 1'b1 || pop_vld !== 1'b0) begin
         errors++; $display("FAIL same_count1: got empty1=%b vld=%b exp 1 0", empty[1], pop_vld);
      end
   endtask

   task automatic test_flush();
      for (int i = 0; i < 6; i++) begin
         set_in(1, 3, 4'(i + 3), 0, 0, 0, 0);
         tick();
      end
      set_in(1, 2, 4'hE, 1, 3, 1, 3);
      checks++;
      if (push_rdy !== 1'b0 || flush_rdy !== 1'b1 || pop_vld !== 1'b0) begin
         errors++; $display("FAIL flush_block: got prdy=%b frdy=%b pvld=%b exp 0 1 0", push_rdy, flush_rdy, pop_vld);
      end
      tick();
      set_in(0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (free_cnt !== 5'd16 || empty[3] !== 1'b1) begin
         errors++; $display("FAIL flush_done: got free=%0d empty3=%b exp 16 1", free_cnt, empty[3]);
      end
      for (int i = 0; i < 16; i++) begin
         set_in(1, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 0, 0, 0, 0);
         checks++;
         if (push_rdy !== 1'b1) begin errors++; $display("FAIL flush_refill %0d: got %b exp 1", i, push_rdy); end
         tick();
      end
      drain("flush");
   endtask

   task automatic test_random();
      bit pv, pr, fv;
      logic [1:0] qid;
      for (int c = 0; c < 400; c++) begin
         pv  = ($urandom_range(0, 9) < 6);
         pr  = ($urandom_range(0, 9) < 4);
         fv  = ($urandom_range(0, 19) == 0);
         qid = 2'($urandom_range(0, 3));
         set_in(pv, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), pr, qid, fv, 2'($urandom_range(0, 3)));
         checks++;
         if (push_rdy !== (!fv && m_free() != 0) || pop_vld !== (!fv && mq[qid].size() != 0)) begin
            errors++; $display("FAIL rnd_rdy c%0d: got prdy=%b pvld=%b", c, push_rdy, pop_vld);
         end
         if (!fv && mq[qid].size() != 0) begin
            checks++;
            if (pop !== mq[qid][0]) begin errors++; $display("FAIL rnd_pop c%0d: got %h exp %h", c, pop, mq[qid][0]); end
         end
         checks++;
         if (free_cnt !== 5'(m_free()) || empty !== m_empty()) begin
            errors++; $display("FAIL rnd_status c%0d: got free=%0d empty=%b exp %0d %b", c, free_cnt, empty, m_free(), m_empty());
         end
         tick();
      end
      drain("rnd");
   endtask

   task automatic test_mid_reset();
      for (int i = 0; i < 7; i++) begin
         set_in(1, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 0, 0, 0, 0);
         tick();
      end
      @(negedge clk);
      rst = 1'b1;
      push_vld = 0; pop_rdy = 0; flush_vld = 0;
      #1;
      for (int l = 0; l < NL; l++) mq[l].delete();
      checks++;
      if ({push_rdy, pop_vld, flush_rdy, init_done} !== 4'b0000 || free_cnt !== 5'd0 || empty !== 4'hF) begin
         errors++;
         $display("FAIL midrst_vals: got rdy/vld/frdy/done=%b free=%0d empty=%b exp 0000 0 1111",
                  {push_rdy, pop_vld, flush_rdy, init_done}, free_cnt, empty);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      wait_init("midrst");
      set_in(1, 3, 4'hB, 0, 3, 0, 0);
      tick();
      set_in(0, 0, 0, 0, 3, 0, 0);
      checks++;
      if (pop_vld !== 1'b1 || pop !== 4'hB) begin
         errors++; $display("FAIL midrst_reuse: got vld=%b d=%h exp 1 b", pop_vld, pop);
      end
      drain("midrst");
   endtask

   initial begin
      test_reset();
      test_fifo_order();
      test_full();
      test_push_pop_same();
      test_flush();
      test_random();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/m_multi_linked_list.md
Name: m_multi_linked_list

Overview:
- Successor to the single-queue linked list. NUM_LISTS independent FIFO queues share one DEPTH-entry storage pool through per-entry next-pointers.
- Unused entries are kept on an internal free list.
- Adds three things the single queue lacks: a selectable list for push and pop, a one-cycle whole-list flush, and occupancy status.
- Sits between a multi-flow producer and consumer (e.g. per-channel reorder/egress queues).

Parameters:
- WIDTH, 4, data bits per entry
- DEPTH, 16, total shared entries (power of 2, >=2)
- NUM_LISTS, 4, number of queues (power of 2, >=2)
- local L2_DEPTH = $clog2(DEPTH), L2_LISTS = $clog2(NUM_LISTS)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- push_vld  in  1  push request
- push_rdy  out  1  push accepted when push_vld && push_rdy
- push_id  in  L2_LISTS  target list for push
- push  in  WIDTH  push data
- pop_id  in  L2_LISTS  list selected for pop
- pop_vld  out  1  head of list pop_id is valid
- pop_rdy  in  1  consumer takes the head
- pop  out  WIDTH  head data of list pop_id
- flush_vld  in  1  flush request
- flush_rdy  out  1  flush accepted
- flush_id  in  L2_LISTS  list to flush
- empty  out  NUM_LISTS  bit i set when list i has 0 entries
- free_cnt  out  L2_DEPTH+1  free entries remaining
- init_done  out  1  pool initialised, block operational

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high (rst).
- Reset values:
  - push_rdy=0, pop_vld=0, flush_rdy=0, init_done=0, free_cnt=0, empty=all 1s.
  - Per-list count=0 and head/tail=0. Storage data is not reset.
- FSM INIT (entered on reset): one entry per cycle, next[i]=i+1, for i=0..DEPTH-1.
  - Takes exactly DEPTH cycles after rst deasserts, then moves to RUN.
  - On entering RUN: free head=0, free tail=DEPTH-1, free_cnt=DEPTH, init_done=1.
  - All handshakes are blocked in INIT.
- FSM RUN: no exit except reset. Reset mid-operation discards all contents and re-enters INIT.
- Ready/valid rules:
  - flush_rdy = RUN.
  - push_rdy = RUN && !flush_vld && free_cnt!=0. There is no bypass: a pop in the same cycle does not make a full pool pushable.
  - pop_vld = RUN && !flush_vld && count[pop_id]!=0.
  - pop = data[head[pop_id]]. It is combinational on pop_id and valid in the same cycle; its value is don't-care when pop_vld=0.
- Push fire:
  - Take entry e = free head and write data[e]=push.
  - If list is empty: head=tail=e. Otherwise next[tail]=e and tail=e.
  - count+1; free head=next[e]; free_cnt-1.
- Pop fire:
  - h = head[pop_id]; head=next[h]; count-1.
  - Append h to the free-list tail; free_cnt+1.
  - When count goes 1->0, the list is empty and its head/tail become don't-care.
- Simultaneous push and pop (any lists, including the same list):
  - Both complete in one cycle; free_cnt is unchanged.
  - Same list with count==1: the list becomes the single pushed entry (head=tail=e), count stays 1.
  - If free_cnt==1, the popped entry h becomes the new free head and tail.
- Flush fire: the whole list is spliced onto the free-list tail in one cycle.
  - next[free tail]=head[id]; free tail=tail[id]; free_cnt += count[id]; count[id]=0.
  - If free_cnt==0 beforehand, free head=head[id].
  - Flushing an empty list is a no-op but still handshakes.
  - Push and pop are suppressed that cycle.
- Invariant: free_cnt + sum(count) == DEPTH at all times in RUN.
- Ordering: FIFO per list; no ordering between lists.

Test Plan:
1. Reset for 3 cycles then release -> init_done rises exactly 16 cycles later, free_cnt=16, empty=4'b1111, push_rdy=1.
2. Push A,B,C to list 2 and D to list 0; pop_id=2 then 0 -> pops A,B,C, then D; empty returns to 4'b1111, free_cnt=16.
3. Push 16 entries round-robin over lists 0-3 -> push_rdy=0 at free_cnt=0. Push+pop in the same cycle -> push is not accepted. Pop one -> push_rdy=1 the next cycle.
4. List 1 holds {5}; push 9 and pop list 1 in the same cycle -> pop=5, list 1 then holds only 9, count=1, free_cnt unchanged.
5. Fill list 3 with 6 entries, flush_id=3 with push_vld held -> push blocked that cycle, then free_cnt=16, empty[3]=1. Subsequent 16 pushes all succeed with correct data.
6. Assert rst mid-stream with 7 entries held -> outputs return to reset values immediately, INIT reruns for 16 cycles, all lists are empty.
